// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: drives a 1-cycle-latency instruction memory, buffers
// returned words with their PC in a small FIFO, and hands them to decode via valid/ready.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  output logic [31:0]       instr_out,
  output logic [31:0]       instr_pc,
  input  logic              instr_ready
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

  state_e            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic              inflight_q, inflight_d;
  logic [31:0]       inflight_pc_q;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [31:0]       mem_instr_q [DEPTH];
  logic [31:0]       mem_pc_q [DEPTH];
  logic [31:0]       head_instr_q, head_instr_d, head_pc_q, head_pc_d;
  logic [CntW:0]     credit;
  logic              issue, push, pop;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   state_d = StRun;
      StRun:    if (halt) state_d = StHalted;
      StHalted: if (!halt) state_d = StRun;
      default:  state_d = StIdle;
    endcase
  end

  // Buffered plus in-flight words must fit, so a returning response can always be pushed.
  assign credit      = {1'b0, count_q} + (CntW + 1)'(inflight_q);
  assign issue       = (state_q == StRun) && (credit < (CntW + 1)'(DEPTH)) && !redirect_valid;
  assign imem_en     = issue;
  assign imem_addr   = issue ? fetch_pc_q[ADDR_W-1:0] : '0;
  assign push        = inflight_q && !redirect_valid;
  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid && instr_ready;
  assign instr_out   = head_instr_q;
  assign instr_pc    = head_pc_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = issue;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + 32'd1;
      if (push)  wr_ptr_d   = wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_d   = rd_ptr_q + 1'b1;
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  // Head registers preload the next head entry; they hold their value when the FIFO empties.
  always_comb begin
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    if (count_d != '0) begin
      if (push && (rd_ptr_d == wr_ptr_q)) begin
        head_instr_d = imem_rdata;
        head_pc_d    = inflight_pc_q;
      end else begin
        head_instr_d = mem_instr_q[rd_ptr_d];
        head_pc_d    = mem_pc_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      head_instr_q  <= '0;
      head_pc_q     <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      inflight_q   <= inflight_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
      if (issue) inflight_pc_q <= fetch_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr_q[wr_ptr_q] <= imem_rdata;
      mem_pc_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, backpressure, redirects, halt, wrap, reset.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_ready;

  logic        imem_en, imem_en5;
  logic [9:0]  imem_addr, imem_addr5;
  logic [31:0] imem_rdata = '0, imem_rdata5 = '0;
  logic        instr_valid, instr_valid5;
  logic [31:0] instr_out, instr_out5, instr_pc, instr_pc5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(10), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .halt(halt), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_out(instr_out),
    .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  instr_fetch_unit #(.ADDR_W(10), .DEPTH(4), .RESET_PC(32'h3FF)) dut5 (
    .clk(clk), .rst(rst), .halt(halt), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_en(imem_en5), .imem_addr(imem_addr5),
    .imem_rdata(imem_rdata5), .instr_valid(instr_valid5), .instr_out(instr_out5),
    .instr_pc(instr_pc5), .instr_ready(instr_ready)
  );

  // Synchronous memories: word k holds 0x1000 + k.
  always @(posedge clk) begin
    if (imem_en)  imem_rdata  <= 32'h1000 + 32'(imem_addr);
    if (imem_en5) imem_rdata5 <= 32'h1000 + 32'(imem_addr5);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  int exp_pc;

  initial begin
    rst = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
    #2;
    chk("rst_en", imem_en, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_out", instr_out, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_addr5", imem_addr5, 0);

    // Release reset mid-cycle 0.
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("idle_en", imem_en, 0);

    cyc();  // cycle 1
    chk("c1_en", imem_en, 1);
    chk("c1_addr", imem_addr, 0);
    chk("c1_addr5", imem_addr5, 10'h3FF);
    cyc();  // cycle 2
    chk("c2_addr", imem_addr, 1);
    chk("c2_valid", instr_valid, 0);
    chk("c2_addr5_wrap", imem_addr5, 0);
    cyc();  // cycle 3
    chk("c3_valid", instr_valid, 1);
    chk("c3_pc", instr_pc, 0);
    chk("c3_out", instr_out, 32'h1000);
    chk("c3_pc5", instr_pc5, 32'h3FF);
    chk("c3_out5", instr_out5, 32'h13FF);
    cyc();  // cycle 4
    chk("c4_pc", instr_pc, 1);
    chk("c4_pc5", instr_pc5, 32'h400);
    chk("c4_out5", instr_out5, 32'h1000);

    exp_pc = 2;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stream_valid", instr_valid, 1);
      chk("stream_pc", instr_pc, exp_pc);
      chk("stream_out", instr_out, 32'h1000 + exp_pc);
      exp_pc++;
    end

    // Backpressure: head pc 7 stalls, FIFO fills, issue stops.
    cyc();
    instr_ready = 1'b0;
    repeat (10) cyc();
    chk("full_en", imem_en, 0);
    chk("full_valid", instr_valid, 1);
    chk("full_pc", instr_pc, exp_pc);
    instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", instr_valid, 1);
      chk("drain_pc", instr_pc, exp_pc);
      chk("drain_out", instr_out, 32'h1000 + exp_pc);
      exp_pc++;
      cyc();
    end

    // Redirect with a full FIFO.
    instr_ready = 1'b0;
    repeat (6) cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1;
    chk("r0_en", imem_en, 0);
    cyc();  // R+1
    redirect_valid = 1'b0; instr_ready = 1'b1;
    #1;
    chk("r1_valid", instr_valid, 0);
    chk("r1_en", imem_en, 1);
    chk("r1_addr", imem_addr, 10'h40);
    cyc();  // R+2
    chk("r2_valid", instr_valid, 0);
    chk("r2_addr", imem_addr, 10'h41);
    cyc();  // R+3
    chk("r3_valid", instr_valid, 1);
    chk("r3_pc", instr_pc, 32'h40);
    chk("r3_out", instr_out, 32'h1040);
    cyc();  // R+4
    chk("r4_pc", instr_pc, 32'h41);
    cyc();  // R+5: redirect while pc 0x43 is in flight
    chk("r5_pc", instr_pc, 32'h42);
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    #1;
    chk("c0_en_masked", imem_en, 0);
    chk("c0_valid_unmasked", instr_valid, 1);
    cyc();  // C+1
    redirect_valid = 1'b0;
    #1;
    chk("x1_valid", instr_valid, 0);
    chk("x1_addr", imem_addr, 10'h80);
    cyc();  // C+2
    chk("x2_valid", instr_valid, 0);
    cyc();  // C+3
    chk("x3_valid", instr_valid, 1);
    chk("x3_pc", instr_pc, 32'h80);
    chk("x3_out", instr_out, 32'h1080);
    cyc();  // C+4
    chk("x4_pc", instr_pc, 32'h81);

    // Halt mid-stream: one last issue, buffer drains, head holds.
    halt = 1'b1;
    #1;
    chk("h0_en", imem_en, 1);
    chk("h0_addr", imem_addr, 10'h83);
    cyc();
    chk("h1_en", imem_en, 0);
    chk("h1_pc", instr_pc, 32'h82);
    cyc();
    chk("h2_valid", instr_valid, 1);
    chk("h2_pc", instr_pc, 32'h83);
    cyc();
    chk("h3_valid", instr_valid, 0);
    chk("h3_en", imem_en, 0);
    chk("h3_pc_hold", instr_pc, 32'h83);
    chk("h3_out_hold", instr_out, 32'h1083);
    cyc();
    chk("h4_valid", instr_valid, 0);
    halt = 1'b0;
    cyc();
    chk("h5_en", imem_en, 1);
    chk("h5_addr", imem_addr, 10'h84);
    cyc();
    cyc();
    chk("h7_pc", instr_pc, 32'h84);

    // Asynchronous reset mid-cycle.
    #3;
    rst = 1'b0;
    #1;
    chk("arst_en", imem_en, 0);
    chk("arst_addr", imem_addr, 0);
    chk("arst_valid", instr_valid, 0);
    chk("arst_out", instr_out, 0);
    chk("arst_pc", instr_pc, 0);
    cyc();
    chk("arst_hold_valid", instr_valid, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    cyc();
    chk("rr1_addr", imem_addr, 0);
    chk("rr1_en", imem_en, 1);
    cyc();
    cyc();
    chk("rr3_valid", instr_valid, 1);
    chk("rr3_pc", instr_pc, 0);
    chk("rr3_out", instr_out, 32'h1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
